instruction_trace_display_unit: RTL and testbench

//  Parametrised successor of the single-channel instruction display path.

---
 rtl/instruction_trace_display_unit.sv | 159 +++++++++++++++
 tb/tb_instruction_trace_display_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_trace_display_unit.sv
// Circular instruction trace RAM rendered as hex character codes for the VGA text renderer.
// Optional macro TRACE_STOP_ON_FULL_EN: one-shot capture that halts when the trace fills.
//
// state | meaning
// RUN   | capturing new instruction words
// HOLD  | FREEZE high, trace held
// STOP  | trace full in one-shot mode, waiting for CLR
module instruction_trace_display_unit #(
  parameter int INS_W  = 32,
  parameter int DEPTH  = 64,
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int X_ORG  = 0,
  parameter int Y_ORG  = 0,
  parameter int ROW_SH = 4,
  parameter int COL_SH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INS_VALID,
  input  logic [INS_W-1:0] INS,
  input  logic             CLR,
  input  logic             FREEZE,
  input  logic [X_W-1:0]   SYS_X,
  input  logic [Y_W-1:0]   SYS_Y,
  output logic [15:0]      C_INS,
  output logic [6:0]       COUNT,
  output logic             FULL,
  output logic             STOPPED
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NDIG = INS_W / 4;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [INS_W-1:0] ram [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [INS_W-1:0] last_word;
  logic             cmp_valid;
  logic [1:0]       state, state_nxt;
  logic             stop_blk;
  logic             capture;

  assign stop_blk = (state == ST_STOP);
  assign capture  = INS_VALID & ~FREEZE & ~stop_blk & ~CLR &
                    (~cmp_valid | (INS != last_word));
  assign FULL     = (COUNT == 7'(DEPTH));

`ifdef TRACE_STOP_ON_FULL_EN
  logic fill_last;
  assign fill_last = (COUNT == 7'(DEPTH - 1));
  assign STOPPED   = stop_blk;
`else
  assign STOPPED   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (FREEZE) state_nxt = ST_HOLD;
      ST_HOLD: if (!FREEZE) state_nxt = ST_RUN;
      ST_STOP: if (CLR) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
`ifdef TRACE_STOP_ON_FULL_EN
    // a filling capture can also happen on the cycle FREEZE drops, while still in HOLD
    if (capture && fill_last) state_nxt = ST_STOP;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      COUNT     <= '0;
      cmp_valid <= 1'b0;
      last_word <= '0;
    end else if (CLR) begin
      wr_ptr    <= '0;
      COUNT     <= '0;
      cmp_valid <= 1'b0;
    end else if (capture) begin
      wr_ptr    <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      COUNT     <= FULL ? COUNT : COUNT + 7'd1;
      cmp_valid <= 1'b1;
      last_word <= INS;
    end
  end

  // RAM is never cleared; stale entries stay hidden behind COUNT
  always_ff @(posedge CLK) begin
    if (capture) ram[wr_ptr] <= INS;
  end

  logic [Y_W-1:0] rel_y, row_full;
  logic [X_W-1:0] rel_x, dig_full;
  logic           in_win, vis_d, newest_d;
  logic [PW-1:0]  oldest, rd_addr_d;
  logic [31:0]    addr_sum;

  always_comb begin
    rel_y     = SYS_Y - Y_W'(Y_ORG);
    rel_x     = SYS_X - X_W'(X_ORG);
    row_full  = rel_y >> ROW_SH;
    dig_full  = rel_x >> COL_SH;
    in_win    = (SYS_Y >= Y_W'(Y_ORG)) && (SYS_X >= X_W'(X_ORG));
    vis_d     = in_win && (32'(row_full) < 32'(COUNT)) && (32'(dig_full) < 32'(NDIG));
    newest_d  = ((32'(row_full) + 32'd1) == 32'(COUNT));
    oldest    = FULL ? wr_ptr : '0;
    addr_sum  = 32'(oldest) + 32'(row_full);
    rd_addr_d = (addr_sum >= 32'(DEPTH)) ? PW'(addr_sum - 32'(DEPTH)) : PW'(addr_sum);
  end

  logic          vis_q, newest_q;
  logic [5:0]    row_q;
  logic [3:0]    dig_q;
  logic [PW-1:0] rd_addr_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vis_q     <= 1'b0;
      newest_q  <= 1'b0;
      row_q     <= '0;
      dig_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      vis_q     <= vis_d;
      newest_q  <= newest_d;
      row_q     <= 6'(row_full);
      dig_q     <= 4'(dig_full);
      rd_addr_q <= rd_addr_d;
    end
  end

  logic [INS_W-1:0] rd_word;
  logic [3:0]       nib;

  // digit 0 is the most-significant nibble
  always_comb begin
    rd_word = ram[rd_addr_q];
    nib     = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (32'(dig_q) == 32'(NDIG - 1 - i)) nib = rd_word[4*i +: 4];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) C_INS <= 16'h0000;
    else      C_INS <= vis_q ? {1'b1, newest_q, row_q, dig_q, nib} : 16'h0000;
  end

endmodule

// File: tb/tb_instruction_trace_display_unit.sv
// Bench for instruction_trace_display_unit: queue-based trace model, per-cycle compare, pinned literals.
// Follows TRACE_STOP_ON_FULL_EN when the build defines it.
module tb_instruction_trace_display_unit;
  localparam int INS_W = 32, DEPTH = 4, X_W = 10, Y_W = 10;
  localparam int X_ORG = 8, Y_ORG = 16, ROW_SH = 4, COL_SH = 3;
`ifdef TRACE_STOP_ON_FULL_EN
  localparam bit STOP_MODE = 1'b1;
`else
  localparam bit STOP_MODE = 1'b0;
`endif

  logic CLK = 1'b0, RST = 1'b0, INS_VALID = 1'b0, CLR = 1'b0, FREEZE = 1'b0;
  logic [INS_W-1:0] INS = '0;
  logic [X_W-1:0] SYS_X = '0;
  logic [Y_W-1:0] SYS_Y = '0;
  logic [15:0] C_INS;
  logic [6:0] COUNT;
  logic FULL, STOPPED;

  int n_vec = 0, n_err = 0;

  instruction_trace_display_unit #(
    .INS_W(INS_W), .DEPTH(DEPTH), .X_W(X_W), .Y_W(Y_W),
    .X_ORG(X_ORG), .Y_ORG(Y_ORG), .ROW_SH(ROW_SH), .COL_SH(COL_SH)
  ) dut (
    .CLK(CLK), .RST(RST), .INS_VALID(INS_VALID), .INS(INS), .CLR(CLR),
    .FREEZE(FREEZE), .SYS_X(SYS_X), .SYS_Y(SYS_Y), .C_INS(C_INS),
    .COUNT(COUNT), .FULL(FULL), .STOPPED(STOPPED)
  );

  always #5 CLK = ~CLK;

  // trace model: oldest-first queue of captured words
  logic [INS_W-1:0] q[$];
  logic [INS_W-1:0] m_last = '0;
  bit m_cmp_v = 0, m_stop = 0;
  int ver = 0;
  bit s1_null = 1;
  int s1_x = 0, s1_y = 0, s1_ver = 0;
  logic [15:0] exp_c = 16'h0;
  bit exp_c_ok = 1;
  int exp_count = 0;
  bit exp_stop = 0;

  function automatic logic [15:0] render(int x, int y);
    int row, dig;
    logic [3:0] nibv;
    logic [INS_W-1:0] w;
    if (x < X_ORG || y < Y_ORG) return 16'h0;
    row = (y - Y_ORG) / 16;
    dig = (x - X_ORG) / 8;
    if (row >= q.size() || dig >= INS_W / 4) return 16'h0;
    w = q[row];
    nibv = 4'(w >> (4 * (INS_W / 4 - 1 - dig)));
    return {1'b1, (row == q.size() - 1), 6'(row), 4'(dig), nibv};
  endfunction

  always @(posedge CLK or negedge RST) begin
    bit cap;
    if (!RST) begin
      q.delete();
      m_cmp_v = 0; m_stop = 0; m_last = '0; ver++;
      s1_null = 1;
      exp_c = 16'h0; exp_c_ok = 1; exp_count = 0; exp_stop = 0;
    end else begin
      // display output is defined only when the trace did not move between the two stages
      if (s1_null) begin exp_c = 16'h0; exp_c_ok = 1; end
      else if (s1_ver == ver) begin exp_c = render(s1_x, s1_y); exp_c_ok = 1; end
      else exp_c_ok = 0;
      s1_null = 0; s1_x = int'(SYS_X); s1_y = int'(SYS_Y); s1_ver = ver;
      cap = INS_VALID && !FREEZE && !m_stop && !CLR && (!m_cmp_v || INS != m_last);
      if (CLR) begin
        q.delete(); m_cmp_v = 0; m_stop = 0; ver++;
      end else if (cap) begin
        q.push_back(INS);
        if (q.size() > DEPTH) void'(q.pop_front());
        m_last = INS; m_cmp_v = 1; ver++;
        if (STOP_MODE && q.size() == DEPTH) m_stop = 1;
      end
      exp_count = q.size();
      exp_stop = m_stop;
    end
  end

  // pinned literal expectations, requested by the stimulus and checked by the compare process
  int pin_req = 0, pin_done = 0;
  bit pin_c_en = 0;
  logic [15:0] pin_c = 16'h0;
  int pin_cnt = 0, pin_full = 0, pin_stop = -1;

  always @(negedge CLK) begin
    n_vec++;
    if (COUNT !== 7'(exp_count)) begin
      n_err++; $display("FAIL count: got %0d want %0d at %0t", COUNT, exp_count, $time);
    end
    n_vec++;
    if (FULL !== (exp_count == DEPTH)) begin
      n_err++; $display("FAIL full: got %0b want %0b at %0t", FULL, (exp_count == DEPTH), $time);
    end
    n_vec++;
    if (STOPPED !== exp_stop) begin
      n_err++; $display("FAIL stopped: got %0b want %0b at %0t", STOPPED, exp_stop, $time);
    end
    if (exp_c_ok) begin
      n_vec++;
      if (C_INS !== exp_c) begin
        n_err++; $display("FAIL c_ins: got %h want %h at %0t", C_INS, exp_c, $time);
      end
    end
    if (pin_req != pin_done) begin
      if (pin_c_en) begin
        n_vec++;
        if (C_INS !== pin_c) begin
          n_err++; $display("FAIL pin_c_ins #%0d: got %h want %h", pin_req, C_INS, pin_c);
        end
      end
      n_vec++;
      if (COUNT !== 7'(pin_cnt)) begin
        n_err++; $display("FAIL pin_count #%0d: got %0d want %0d", pin_req, COUNT, pin_cnt);
      end
      n_vec++;
      if (FULL !== pin_full[0]) begin
        n_err++; $display("FAIL pin_full #%0d: got %0b want %0d", pin_req, FULL, pin_full);
      end
      if (pin_stop >= 0) begin
        n_vec++;
        if (STOPPED !== pin_stop[0]) begin
          n_err++; $display("FAIL pin_stopped #%0d: got %0b want %0d", pin_req, STOPPED, pin_stop);
        end
      end
      pin_done = pin_req;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic pin(input bit c_en, input logic [15:0] c, input int cnt, input int full, input int stop);
    pin_c_en = c_en; pin_c = c; pin_cnt = cnt; pin_full = full; pin_stop = stop;
    pin_req++;
    @(negedge CLK); #1;
  endtask

  initial begin
    logic [31:0] seq [6];
    logic [31:0] pool [6];
    int pv;
    seq = '{32'h1000000A, 32'h2000000B, 32'h3000000C, 32'h4000000D, 32'h5000000E, 32'h6000000F};

    tick(3);
    RST = 1'b1;
    tick(1);
    pin(1, 16'h0000, 0, 0, 0);

    INS_VALID = 1; INS = 32'hE3A01005; SYS_X = 10'd8; SYS_Y = 10'd16;
    tick(3);
    pin(1, 16'hC00E, 1, 0, 0);
    SYS_X = 10'd64;
    tick(2);
    pin(1, 16'hC075, 1, 0, 0);
    SYS_X = 10'd7;
    tick(2);
    pin(1, 16'h0000, 1, 0, 0);
    tick(10);
    pin(0, 16'h0, 1, 0, 0);

    INS_VALID = 0; CLR = 1;
    tick(1);
    CLR = 0;
    pin(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      INS = seq[i]; INS_VALID = 1;
      tick(1);
    end
    INS_VALID = 0; SYS_X = 10'd8; SYS_Y = 10'd16;
    tick(2);
    pin(1, STOP_MODE ? 16'h8001 : 16'h8003, 4, 1, STOP_MODE ? 1 : 0);
    SYS_X = 10'd64; SYS_Y = 10'd64;
    tick(2);
    pin(1, STOP_MODE ? 16'hC37D : 16'hC37F, 4, 1, STOP_MODE ? 1 : 0);
    CLR = 1;
    tick(1);
    CLR = 0;
    pin(0, 16'h0, 0, 0, 0);

    FREEZE = 1; INS_VALID = 1;
    for (int i = 0; i < 3; i++) begin
      INS = 32'hF0000000 + i;
      tick(1);
    end
    pin(0, 16'h0, 0, 0, 0);
    FREEZE = 0; INS = 32'h12345678;
    tick(1);
    pin(0, 16'h0, 1, 0, 0);

    INS = 32'h87654321; CLR = 1;
    tick(1);
    CLR = 0; INS_VALID = 0;
    pin(0, 16'h0, 0, 0, 0);

    INS_VALID = 1; INS = 32'hCAFE0001;
    tick(1);
    INS = 32'hCAFE0002;
    tick(1);
    INS_VALID = 0; SYS_X = 10'd8; SYS_Y = 10'd16;
    tick(3);
    #1 RST = 1'b0;
    pin(1, 16'h0000, 0, 0, 0);
    RST = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) pool[i] = $urandom;
    pool[5] = pool[0];
    for (int seg = 0; seg < 40; seg++) begin
      pv = $urandom_range(0, 100);
      for (int c = 0; c < 50; c++) begin
        INS_VALID = ($urandom_range(0, 99) < pv);
        INS = pool[$urandom_range(0, 5)];
        FREEZE = ($urandom_range(0, 99) < 8);
        CLR = ($urandom_range(0, 99) < 3);
        SYS_X = X_W'($urandom_range(0, 100));
        SYS_Y = Y_W'($urandom_range(0, 100));
        tick(1);
      end
    end
    INS_VALID = 0; FREEZE = 0; CLR = 0;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
